// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
//   Shared definitions for the IF/ID hazard controller:
//   - default register-index width (REG_ADDR_WIDTH macro, 5 unless predefined)
//   - RV32 opcode constants used by the operand-usage decode
//   - controller state encoding (RUN=0, FLUSH=1, IMEM_WAIT=2)
//   - helpers telling whether an opcode reads rs1 / rs2
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package pipeline_hazard_ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_IMEM_WAIT = 2'd2
  } hz_state_e;

  // Everything except U-type and JAL reads rs1.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  endfunction

  // Only R-type, stores and branches read rs2.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
  endfunction

endpackage

// File: rtl/hazard_load_use_det.sv
// hazard_load_use_det
//   Combinational load-use detector: flags when the load in EX writes a
//   register the instruction in ID actually reads.
// Ports:
//   opcode    in  7   opcode of the instruction in ID
//   rs1, rs2  in  RA  source register fields of the instruction in ID
//   mem_read  in  1   instruction in EX is a load
//   rd        in  RA  destination of the instruction in EX
//   load_use  out 1   ID must stall one cycle
module hazard_load_use_det
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
  input  logic [6:0]                opcode,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic                      mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  output logic                      load_use
);

  logic use_rs1;
  logic use_rs2;

  assign use_rs1 = uses_rs1(opcode);
  assign use_rs2 = uses_rs2(opcode);

  // x0 is never a real dependency.
  assign load_use = mem_read && (rd != '0) &&
                    ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequences the PC and IF/ID register from load-use hazards, EX-stage
//   redirects and instruction-memory wait states.
//   Per-cycle priority: reset > EX_redirect > !imem_ready > load_use > normal.
//   FLUSH holds IF_flush for FLUSH_CYCLES cycles (redirect cycle included);
//   IMEM_WAIT counts consecutive not-ready cycles and raises a sticky
//   imem_err at IMEM_TIMEOUT.
// Optional feature: define HAZARD_PERF_CNT_EN to get stall/flush cycle
//   counters; otherwise both perf ports read 0 and no counter flops exist.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   IF_ID_inst_opcode/rs1/rs2        fields of the instruction in ID
//   ID_EX_mem_read, ID_EX_rd         load flag and rd of the instruction in EX
//   EX_redirect                      taken branch/jump resolved in EX
//   imem_ready                       fetch data valid this cycle
//   pc_write, IF_ID_write            PC and IF/ID enables
//   IF_flush, ID_EX_bubble           IF/ID NOP load, ID/EX control squash
//   imem_err                         sticky fetch-timeout flag (registered)
//   perf_stall_cnt, perf_flush_cnt   32-bit cycle counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned IMEM_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      ID_EX_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_redirect,
  input  logic                      imem_ready,
  output logic                      pc_write,
  output logic                      IF_ID_write,
  output logic                      IF_flush,
  output logic                      ID_EX_bubble,
  output logic                      imem_err,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_flush_cnt
);

  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT    = 16'(IMEM_TIMEOUT);

  hz_state_e   state;
  logic [3:0]  flush_cnt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        load_use;

  hazard_load_use_det #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use_det (
    .opcode  (IF_ID_inst_opcode),
    .rs1     (IF_ID_rs1),
    .rs2     (IF_ID_rs2),
    .mem_read(ID_EX_mem_read),
    .rd      (ID_EX_rd),
    .load_use(load_use)
  );

  assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_flush     = 1'b0;
    ID_EX_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_flush     = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (EX_redirect) begin
      IF_ID_write  = 1'b0;
      IF_flush     = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (state == ST_FLUSH) begin
      // PC only advances past the redirect target when the fetch lands.
      pc_write     = imem_ready;
      IF_ID_write  = 1'b0;
      IF_flush     = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (!imem_ready || load_use) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      imem_err  <= 1'b0;
    end else if (EX_redirect) begin
      flush_cnt <= FLUSH_LOAD;
      wait_cnt  <= '0;
      state     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state)
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt == 4'd1) state <= ST_RUN;
        end
        default: begin
          if (!imem_ready) begin
            state    <= ST_IMEM_WAIT;
            wait_cnt <= wait_inc;
            // Flag on the edge the count reaches the limit; sticky until reset.
            if (wait_inc >= TIMEOUT) imem_err <= 1'b1;
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // The reset branch wins, so the forced IF_flush during reset is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!IF_ID_write && !IF_flush) stall_q <= stall_q + 32'd1;
      if (IF_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
